pu_msp430_spi: RTL and testbench
================================

PU_MSP430_SPI -- requirements
Module: pu_msp430_spi

Interface
REQ-001 Parameter BASE_ADDR, default 15'h00A0, byte base address of the 8-byte register window (0x00A0-0x00A7).
REQ-002 mclk  input  1  main system clock; all logic on its rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 per_addr  input  14  peripheral word address (byte address bits [14:1]).
REQ-005 per_din  input  16  peripheral write data.
REQ-006 per_en  input  1  peripheral access enable, active high.
REQ-007 per_we  input  2  byte write enables; bit0 low byte, bit1 high byte; 2'b00 with per_en is a read.
REQ-008 per_dout  output  16  read data; 16'h0000 when the window is not selected.
REQ-009 irq_spi  output  1  level interrupt to the irq bus.
REQ-010 spi_sck  output  1  serial clock.
REQ-011 spi_mosi  output  1  master data out.
REQ-012 spi_miso  input  1  master data in, sampled in the mclk domain.
REQ-013 spi_cs_n  output  1  chip select, active low, software-driven.

Function
REQ-014 Window selected when per_en=1 and per_addr[13:2]==BASE_ADDR[14:3]; per_addr[1:0] indexes CTL(0), STAT(1), TXBUF(2), RXBUF(3).
REQ-015 CTL: bit0 EN, bit1 CPOL, bit2 CPHA, bit3 IE_RX, bit4 IE_TX, bit5 CS (spi_cs_n = ~CS), bits[15:8] DIV; bits[7:6] read 0; byte-writable per per_we.
REQ-016 STAT: bit0 BUSY, bit1 TXE, bit2 RXF, bit3 OVR, others 0; writing 1 to bit2/bit3 clears RXF/OVR; other bits read-only.
REQ-017 TXBUF write (per_we[0]=1) loads 8-bit holding register and clears TXE when TXE=1; write when TXE=0 is dropped; reads return {8'h00, holding}.
REQ-018 RXBUF read returns {8'h00, rx byte} combinationally and clears RXF on that same edge; writes ignored.
REQ-019 per_dout combinational from register state during the selected cycle.
REQ-020 FSM states IDLE, SHIFT, DONE.
REQ-021 IDLE -> SHIFT on the edge after EN=1 and TXE=0: shift register <= holding, TXE <= 1, BUSY <= 1, bit counter <= 0, divider <= DIV.
REQ-022 SHIFT: divider counts DIV down to 0, one SCK half-period = DIV+1 mclk cycles; at 0 toggle spi_sck and reload; 16 half-periods per byte, MSB first.
REQ-023 CPHA=0: MOSI driven from shift[7] on entry to SHIFT; MISO sampled on leading SCK edge; shift on trailing edge. CPHA=1: shift out on leading edge, sample on trailing edge.
REQ-024 spi_sck = CPOL in IDLE and DONE; leading edge = first transition away from CPOL.
REQ-025 After 16th half-period SHIFT -> DONE; DONE: RXBUF <= received byte, RXF <= 1, OVR <= 1 if RXF was already 1 (RXBUF overwritten), BUSY <= 0, -> IDLE.
REQ-026 Latency: RXF visible 16*(DIV+1)+2 mclk cycles after the TXBUF write edge; back-to-back bytes start from IDLE the next edge if TXE=0.
REQ-027 TXBUF write during SHIFT with TXE=1 refills holding without disturbing the active byte.
REQ-028 EN cleared mid-transfer: next edge FSM -> IDLE, spi_sck <= CPOL, BUSY <= 0, TXE <= 1, RXF/RXBUF unchanged.
REQ-029 RXBUF read and DONE on the same edge: DONE wins, RXF=1, OVR unchanged by the read.
REQ-030 Write-1-clear of RXF and DONE on the same edge: DONE wins.
REQ-031 CTL writes to CPOL/CPHA/DIV while BUSY take effect at the next byte only (latched at IDLE->SHIFT).
REQ-032 irq_spi = (IE_RX & RXF) | (IE_TX & TXE & EN).

Reset
REQ-033 reset_n=0 asynchronously: CTL=16'h0000, holding=8'h00, RXBUF=8'h00, TXE=1, RXF=0, OVR=0, BUSY=0, FSM=IDLE.
REQ-034 During reset: spi_sck=0, spi_mosi=0, spi_cs_n=1, irq_spi=0, per_dout=16'h0000.

Verification
REQ-035 CTL=16'h0121 (DIV=1, EN, CS), write TXBUF=8'hA5, MISO loops MOSI -> spi_cs_n=0, 8 SCK pulses of 4 mclk, RXF at cycle 34, RXBUF=8'hA5.
REQ-036 Modes 0-3, DIV=0, TX 8'h3C, MISO driven 8'hC3 by slave model -> correct edges per CPOL/CPHA, RXBUF=8'hC3 each mode.
REQ-037 Two bytes without reading RXBUF -> second DONE sets OVR=1, RXBUF=second byte; write STAT=16'h000C -> RXF=OVR=0.
REQ-038 Clear EN after 5 half-periods -> spi_sck returns to CPOL next cycle, BUSY=0, TXE=1, RXF stays 0.
REQ-039 IE_TX=1, EN=1 -> irq_spi=1 while TXE=1, drops the cycle after TXBUF write; IE_RX=1 -> irq_spi=1 on RXF, clears on RXBUF read.
REQ-040 Assert reset_n=0 mid-SHIFT -> all outputs reach REQ-034 values without waiting for a clock edge.

Source files
------------

// File: rtl/pu_msp430_spi.sv
// ---------------------------------------------------------------------------
// pu_msp430_spi -- memory-mapped SPI master for the MSP430 peripheral bus.
//
// Register window (4 words at BASE_ADDR):
//   +0 CTL   : [0] EN [1] CPOL [2] CPHA [3] IE_RX [4] IE_TX [5] CS [15:8] DIV
//   +2 STAT  : [0] BUSY [1] TXE [2] RXF [3] OVR (write 1 to clear RXF/OVR)
//   +4 TXBUF : 8-bit holding register, accepted only while TXE=1
//   +6 RXBUF : last received byte, reading it clears RXF
//
// Ports:
//   mclk, reset_n            clock and asynchronous active-low reset
//   per_addr/din/en/we       peripheral bus access (word address, byte WEs)
//   per_dout                 read data, zero when the window is not selected
//   irq_spi                  level interrupt (RX full and/or TX empty)
//   spi_sck/mosi/miso/cs_n   SPI pins, MISO sampled directly in mclk domain
// ---------------------------------------------------------------------------
module pu_msp430_spi #(
  parameter logic [14:0] BASE_ADDR = 15'h00A0
) (
  input  logic        mclk,
  input  logic        reset_n,
  input  logic [13:0] per_addr,
  input  logic [15:0] per_din,
  input  logic        per_en,
  input  logic [1:0]  per_we,
  output logic [15:0] per_dout,
  output logic        irq_spi,
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      state, state_nxt;

  logic        ctl_en, ctl_cpol, ctl_cpha, ctl_ie_rx, ctl_ie_tx, ctl_cs;
  logic [7:0]  ctl_div;
  logic [7:0]  holding, rx_buf;
  logic        txe, rxf, ovr;
  logic        sck_r, mosi_r;

  logic [7:0]  tx_sh, rx_sh;
  logic [7:0]  div_cnt, div_l;
  logic [3:0]  half_cnt;
  logic        cpha_l;

  logic        sel;
  logic [1:0]  reg_idx;
  logic        wr_ctl_lo, wr_ctl_hi, wr_stat, wr_tx, rd_rx;

  logic        busy, start, tick, sck_edge, leading, trailing;
  logic        do_sample, do_shift, last_half, abort, done;

  assign sel       = per_en && (per_addr[13:2] == BASE_ADDR[14:3]);
  assign reg_idx   = per_addr[1:0];
  assign wr_ctl_lo = sel && (reg_idx == 2'd0) && per_we[0];
  assign wr_ctl_hi = sel && (reg_idx == 2'd0) && per_we[1];
  assign wr_stat   = sel && (reg_idx == 2'd1) && per_we[0];
  assign wr_tx     = sel && (reg_idx == 2'd2) && per_we[0];
  assign rd_rx     = sel && (reg_idx == 2'd3) && (per_we == 2'b00);

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_SHIFT;
      S_SHIFT: begin
        if (!ctl_en)        state_nxt = S_IDLE;
        else if (last_half) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Half-period index parity tells leading (even) from trailing (odd) edges;
  // CPHA, latched at byte start, decides which of them samples and which shifts.
  always_comb begin
    busy      = (state != S_IDLE);
    start     = (state == S_IDLE) && ctl_en && !txe;
    tick      = (div_cnt == 8'd0);
    sck_edge  = (state == S_SHIFT) && ctl_en && tick;
    leading   = sck_edge && !half_cnt[0];
    trailing  = sck_edge && half_cnt[0];
    do_sample = cpha_l ? trailing : leading;
    do_shift  = cpha_l ? leading : trailing;
    last_half = sck_edge && (half_cnt == 4'd15);
    abort     = (state == S_SHIFT) && !ctl_en;
    done      = (state == S_DONE);
  end

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      {ctl_cs, ctl_ie_tx, ctl_ie_rx, ctl_cpha, ctl_cpol, ctl_en} <= 6'b0;
      ctl_div <= 8'h00;
      holding <= 8'h00;
      rx_buf  <= 8'h00;
      txe     <= 1'b1;
      rxf     <= 1'b0;
      ovr     <= 1'b0;
      sck_r   <= 1'b0;
      mosi_r  <= 1'b0;
    end else begin
      if (wr_ctl_lo) {ctl_cs, ctl_ie_tx, ctl_ie_rx, ctl_cpha, ctl_cpol, ctl_en} <= per_din[5:0];
      if (wr_ctl_hi) ctl_div <= per_din[15:8];

      if (wr_tx && txe) begin
        holding <= per_din[7:0];
        txe     <= 1'b0;
      end
      if (start) begin
        txe    <= 1'b1;
        mosi_r <= holding[7];
      end
      // Abort wins over a same-edge TXBUF write: the buffer is reported empty.
      if (abort) txe <= 1'b1;

      if ((state == S_SHIFT) && !abort) begin
        if (sck_edge) sck_r <= ~sck_r;
      end else begin
        sck_r <= ctl_cpol;
      end
      if (do_shift) mosi_r <= tx_sh[7];

      // Completion has priority over both the RXBUF-read and write-1 clears.
      if (done) begin
        rx_buf <= rx_sh;
        rxf    <= 1'b1;
        ovr    <= rxf | (ovr & !(wr_stat && per_din[3]));
      end else begin
        if (rd_rx || (wr_stat && per_din[2])) rxf <= 1'b0;
        if (wr_stat && per_din[3])            ovr <= 1'b0;
      end
    end
  end

  // Shift datapath: fully reloaded at every byte start, so no reset needed.
  // CPHA=0 has already presented bit 7 on MOSI, hence the pre-shifted load.
  always_ff @(posedge mclk) begin
    if (start) begin
      tx_sh    <= ctl_cpha ? holding : {holding[6:0], 1'b0};
      half_cnt <= 4'd0;
      div_cnt  <= ctl_div;
      div_l    <= ctl_div;
      cpha_l   <= ctl_cpha;
    end else if (state == S_SHIFT) begin
      if (tick) begin
        div_cnt  <= div_l;
        half_cnt <= half_cnt + 4'd1;
      end else begin
        div_cnt  <= div_cnt - 8'd1;
      end
      if (do_sample) rx_sh <= {rx_sh[6:0], spi_miso};
      if (do_shift)  tx_sh <= {tx_sh[6:0], 1'b0};
    end
  end

  always_comb begin
    per_dout = 16'h0000;
    if (sel && reset_n) begin
      case (reg_idx)
        2'd0:    per_dout = {ctl_div, 2'b00, ctl_cs, ctl_ie_tx, ctl_ie_rx, ctl_cpha, ctl_cpol, ctl_en};
        2'd1:    per_dout = {12'h000, ovr, rxf, txe, busy};
        2'd2:    per_dout = {8'h00, holding};
        default: per_dout = {8'h00, rx_buf};
      endcase
    end
  end

  assign irq_spi  = (ctl_ie_rx & rxf) | (ctl_ie_tx & txe & ctl_en);
  assign spi_sck  = sck_r;
  assign spi_mosi = mosi_r;
  assign spi_cs_n = ~ctl_cs;

endmodule

// File: tb/tb_pu_msp430_spi.sv
// ---------------------------------------------------------------------------
// tb_pu_msp430_spi -- scoreboard bench for pu_msp430_spi.
// Stimulus pushes expected bus read data / pin observations into a queue; a
// monitor pops and compares on every bus read cycle and every pin-check cycle.
// ---------------------------------------------------------------------------
module tb_pu_msp430_spi;

  localparam logic [13:0] WBASE    = 14'h0050;
  localparam logic [7:0]  SLV_BYTE = 8'hC3;

  logic        mclk = 1'b0;
  logic        reset_n;
  logic [13:0] per_addr;
  logic [15:0] per_din;
  logic        per_en;
  logic [1:0]  per_we;
  logic [15:0] per_dout;
  logic        irq_spi, spi_sck, spi_mosi, spi_miso, spi_cs_n;

  logic        loop_en, pin_chk, tb_done;
  logic        sck_clr, sl_load, slave_on, sl_cpol, sl_cpha, miso_sl;
  logic [7:0]  sl_sh;
  logic [7:0]  sck_rises;
  logic [15:0] obs;

  typedef struct {
    bit          pin;
    logic [15:0] exp;
    logic [15:0] mask;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_err;

  always #5 mclk = ~mclk;

  pu_msp430_spi #(.BASE_ADDR(15'h00A0)) dut (
    .mclk     (mclk),
    .reset_n  (reset_n),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_we   (per_we),
    .per_dout (per_dout),
    .irq_spi  (irq_spi),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  assign spi_miso = loop_en ? spi_mosi : miso_sl;
  assign obs      = {sck_rises, 4'h0, irq_spi, spi_sck, spi_mosi, spi_cs_n};

  always @(posedge spi_sck or posedge sck_clr) begin
    if (sck_clr) sck_rises <= 8'd0;
    else         sck_rises <= sck_rises + 8'd1;
  end

  // Slave model: CPHA=0 presents the next bit on the trailing edge (first bit
  // preloaded), CPHA=1 presents each bit on the leading edge.
  always @(spi_sck or posedge sl_load) begin
    if (sl_load) begin
      sl_sh   <= sl_cpha ? SLV_BYTE : {SLV_BYTE[6:0], 1'b0};
      miso_sl <= SLV_BYTE[7];
    end else if (slave_on && ((spi_sck != sl_cpol) == sl_cpha)) begin
      miso_sl <= sl_sh[7];
      sl_sh   <= {sl_sh[6:0], 1'b0};
    end
  end

  task automatic check_one(input bit is_pin, input logic [15:0] act);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_%s: got %h with nothing queued", is_pin ? "pin" : "read", act);
    end else begin
      e = exp_q.pop_front();
      if ((e.pin != is_pin) || ((act & e.mask) !== (e.exp & e.mask))) begin
        n_err++;
        $display("FAIL %s: got %h required %h", e.nm, act & e.mask, e.exp & e.mask);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    @(negedge mclk);
    while (!tb_done) begin
      if (per_en && (per_we == 2'b00)) check_one(1'b0, per_dout);
      if (pin_chk)                     check_one(1'b1, obs);
      @(negedge mclk);
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL leftover: got %0d unchecked expectations required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge mclk);
      #1;
    end
  endtask

  task automatic bus(input logic [13:0] a, input logic [1:0] we, input logic [15:0] d,
                     input logic [15:0] e, input string nm);
    if (we == 2'b00) exp_q.push_back('{pin: 1'b0, exp: e, mask: 16'hFFFF, nm: nm});
    per_addr = a;
    per_we   = we;
    per_din  = d;
    per_en   = 1'b1;
    @(posedge mclk);
    #1;
    per_en   = 1'b0;
    per_we   = 2'b00;
  endtask

  task automatic wr(input int idx, input logic [1:0] we, input logic [15:0] d);
    bus(WBASE + 14'(idx), we, d, 16'h0000, "");
  endtask

  task automatic rd(input int idx, input logic [15:0] e, input string nm);
    bus(WBASE + 14'(idx), 2'b00, 16'h0000, e, nm);
  endtask

  task automatic pin(input logic [15:0] e, input logic [15:0] m, input string nm);
    exp_q.push_back('{pin: 1'b1, exp: e, mask: m, nm: nm});
    pin_chk = 1'b1;
    @(posedge mclk);
    #1;
    pin_chk = 1'b0;
  endtask

  initial begin
    logic cp, ch;
    reset_n  = 1'b0;
    per_addr = 14'h0;
    per_din  = 16'h0;
    per_en   = 1'b0;
    per_we   = 2'b00;
    loop_en  = 1'b1;
    pin_chk  = 1'b0;
    tb_done  = 1'b0;
    sl_load  = 1'b0;
    slave_on = 1'b0;
    sl_cpol  = 1'b0;
    sl_cpha  = 1'b0;
    sck_clr  = 1'b1;
    #1 sck_clr = 1'b0;

    // Reset state
    idle(3);
    pin(16'h0001, 16'h000F, "reset_pins");
    rd(1, 16'h0000, "reset_dout");
    reset_n = 1'b1;
    rd(0, 16'h0000, "rst_ctl");
    rd(1, 16'h0002, "rst_stat");
    rd(2, 16'h0000, "rst_txbuf");
    rd(3, 16'h0000, "rst_rxbuf");
    pin(16'h0001, 16'h000F, "rst_pins_after");
    bus(WBASE + 14'd4, 2'b00, 16'h0, 16'h0000, "unselected_hi");
    bus(WBASE - 14'd1, 2'b00, 16'h0, 16'h0000, "unselected_lo");

    // CTL field masking and byte enables
    wr(0, 2'b11, 16'hFFFF);
    rd(0, 16'hFF3F, "ctl_mask");
    wr(0, 2'b11, 16'h0000);
    wr(0, 2'b10, 16'h12FF);
    rd(0, 16'h1200, "ctl_hi_byte");
    wr(0, 2'b11, 16'h0000);

    // TXBUF accept / drop while disabled, then send the held byte
    wr(2, 2'b01, 16'h005A);
    rd(2, 16'h005A, "txbuf_load");
    rd(1, 16'h0000, "stat_txe_clr");
    wr(2, 2'b01, 16'h0099);
    rd(2, 16'h005A, "txbuf_drop");
    wr(0, 2'b11, 16'h0021);
    idle(20);
    rd(3, 16'h005A, "held_byte_rx");
    rd(1, 16'h0002, "stat_after_rd");

    // DIV=1 loopback: SCK timing and RXF latency of 34 cycles
    sck_clr = 1'b1;
    #1 sck_clr = 1'b0;
    wr(0, 2'b11, 16'h0121);
    pin(16'h0000, 16'h0001, "cs_n_low");
    wr(2, 2'b01, 16'h00A5);
    idle(3);
    pin(16'h0004, 16'h0004, "sck_hi_c3");
    pin(16'h0004, 16'h0004, "sck_hi_c4");
    pin(16'h0000, 16'h0004, "sck_lo_c5");
    idle(27);
    rd(1, 16'h0003, "stat_c33");
    rd(1, 16'h0006, "stat_c34");
    pin(16'h0800, 16'hFF04, "sck_8_pulses");
    rd(3, 16'h00A5, "loop_a5");
    rd(1, 16'h0002, "rxf_clr_read");

    // SPI modes 0-3, DIV=0, slave returns C3
    loop_en = 1'b0;
    for (int m = 0; m < 4; m++) begin
      cp = m[1];
      ch = m[0];
      slave_on = 1'b0;
      wr(0, 2'b11, {8'h00, 2'b00, 1'b1, 1'b0, 1'b0, ch, cp, 1'b1});
      idle(2);
      pin({13'h0, cp, 2'b00}, 16'h0004, $sformatf("mode%0d_idle_sck", m));
      sl_cpol = cp;
      sl_cpha = ch;
      sl_load = 1'b1;
      #1 sl_load = 1'b0;
      slave_on = 1'b1;
      sck_clr = 1'b1;
      #1 sck_clr = 1'b0;
      wr(2, 2'b01, 16'h003C);
      idle(19);
      slave_on = 1'b0;
      pin({8'd8, 5'h0, cp, 2'b00}, 16'hFF04, $sformatf("mode%0d_edges", m));
      rd(3, 16'h00C3, $sformatf("mode%0d_rxbuf", m));
      rd(1, 16'h0002, $sformatf("mode%0d_stat", m));
    end

    // RXBUF read on the DONE edge: completion wins
    loop_en = 1'b1;
    wr(0, 2'b11, 16'h0021);
    wr(2, 2'b01, 16'h003C);
    idle(17);
    rd(3, 16'h00C3, "rd_on_done_old");
    rd(1, 16'h0006, "rd_on_done_rxf");
    rd(3, 16'h003C, "rd_on_done_new");

    // Refill during SHIFT, back-to-back bytes, overrun and write-1-clear
    wr(2, 2'b01, 16'h0011);
    idle(2);
    wr(2, 2'b01, 16'h0022);
    idle(17);
    rd(1, 16'h0007, "b2b_second_busy");
    idle(19);
    rd(1, 16'h000E, "ovr_set");
    rd(3, 16'h0022, "ovr_rxbuf");
    rd(1, 16'h000A, "ovr_after_rd");
    wr(1, 2'b01, 16'h000C);
    rd(1, 16'h0002, "w1c_clear");

    // EN cleared after 5 half-periods
    wr(0, 2'b11, 16'h0121);
    wr(2, 2'b01, 16'h005A);
    idle(11);
    wr(0, 2'b11, 16'h0120);
    pin(16'h0004, 16'h0004, "abort_sck_hi");
    pin(16'h0000, 16'h0004, "abort_sck_cpol");
    rd(1, 16'h0002, "abort_stat");
    rd(3, 16'h0022, "abort_rxbuf_kept");

    // Interrupts
    wr(0, 2'b11, 16'h0011);
    pin(16'h0008, 16'h0008, "irq_tx_on");
    wr(2, 2'b01, 16'h0066);
    pin(16'h0000, 16'h0008, "irq_tx_drop");
    idle(20);
    rd(3, 16'h0066, "irq_tx_rx");
    wr(0, 2'b11, 16'h0009);
    pin(16'h0000, 16'h0008, "irq_rx_idle");
    wr(2, 2'b01, 16'h0077);
    idle(20);
    pin(16'h0008, 16'h0008, "irq_rx_on");
    rd(3, 16'h0077, "irq_rx_data");
    pin(16'h0000, 16'h0008, "irq_rx_clr");

    // Asynchronous reset mid-SHIFT
    wr(0, 2'b11, 16'h0133);
    idle(2);
    wr(2, 2'b01, 16'h00FF);
    idle(6);
    #1 reset_n = 1'b0;
    pin(16'h0001, 16'h000F, "async_rst_pins");
    rd(1, 16'h0000, "async_rst_dout");
    reset_n = 1'b1;
    rd(0, 16'h0000, "post_rst_ctl");
    rd(1, 16'h0002, "post_rst_stat");
    pin(16'h0001, 16'h000F, "post_rst_pins");

    tb_done = 1'b1;
    idle(2);
  end

endmodule
